// File: rtl/riscv_types.sv
`default_nettype none
// ============================================================================
// Module      : riscv_types (package)
// Description : Pipeline stage indices and data-memory FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_types;

    localparam int c_STG_IF    = 0;  // IF1/IF2
    localparam int c_STG_IFID  = 1;
    localparam int c_STG_IDEX  = 2;
    localparam int c_STG_EXMEM = 3;
    localparam int c_STG_MEMWB = 4;
    localparam int c_NUM_STG   = 5;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_ERR  = 2'd2
    } dm_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard detection between ID and EX.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_to_reg,
    output logic       load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use  = ex_mem_to_reg && (ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush control for a 5-stage pipeline with a timed data-memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import riscv_types::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_to_reg,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    input  logic             cnt_clr,
    output logic             pc_wen,
    output logic [4:0]       stage_wen,
    output logic [4:0]       stage_clr,
    output logic             dmem_valid,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       dm_state
);

    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

    dm_state_t           r_state;
    dm_state_t           w_next_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_next_wait;
    logic                r_run;
    logic                r_bus_err;
    logic [CNT_W-1:0]    r_stall_count;
    logic                w_mem_stall;
    logic                w_load_use;

    hazard_detect u_hazard_detect (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_to_reg (ex_mem_to_reg),
        .load_use      (w_load_use)
    );

    assign dmem_valid  = mem_req && r_run && ((r_state == DM_IDLE) || (r_state == DM_WAIT));
    assign w_mem_stall = dmem_valid && !dmem_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= DM_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        case (r_state)
            DM_IDLE: begin
                if (w_mem_stall) begin
                    w_next_state = DM_WAIT;
                    w_next_wait  = c_WAIT_W'(1);
                end
            end
            DM_WAIT: begin
                if (dmem_ready) begin
                    w_next_state = DM_IDLE;
                    w_next_wait  = '0;
                end else if (r_wait_cnt >= c_WAIT_W'(TIMEOUT - 1)) begin
                    w_next_state = DM_ERR;
                    w_next_wait  = '0;
                end else begin
                    w_next_wait  = r_wait_cnt + c_WAIT_W'(1);
                end
            end
            DM_ERR: begin
                // Aborted access is treated as complete; the pipeline moves on.
                w_next_state = DM_IDLE;
                w_next_wait  = '0;
            end
            default: begin
                w_next_state = DM_IDLE;
                w_next_wait  = '0;
            end
        endcase
    end

    // Output logic: stall/flush priority mem_stall > redirect > load_use > fetch
    always_comb begin
        pc_wen    = 1'b1;
        stage_wen = '1;
        stage_clr = '0;
        if (!r_run) begin
            pc_wen    = 1'b0;
            stage_wen = '0;
            stage_clr = '1;
        end else if (w_mem_stall) begin
            pc_wen                             = 1'b0;
            stage_wen[c_STG_EXMEM:c_STG_IF]    = '0;
            stage_clr[c_STG_MEMWB]             = 1'b1;
        end else if (ex_redirect) begin
            stage_clr[c_STG_IDEX:c_STG_IF]     = '1;
        end else if (w_load_use) begin
            pc_wen                             = 1'b0;
            stage_wen[c_STG_IFID:c_STG_IF]     = '0;
            stage_clr[c_STG_IDEX]              = 1'b1;
        end else if (!imem_ready) begin
            pc_wen                             = 1'b0;
            stage_wen[c_STG_IF]                = 1'b0;
            stage_clr[c_STG_IFID]              = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run         <= 1'b0;
            r_bus_err     <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_next_state == DM_ERR)
                r_bus_err <= 1'b1;
            if (cnt_clr)
                r_stall_count <= '0;
            else if (r_run && !pc_wen && !(&r_stall_count))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign bus_err     = r_bus_err;
    assign stall_count = r_stall_count;
    assign dm_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Scoreboard bench for pipeline_ctrl with hand-computed directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_to_reg, ex_redirect;
    logic       mem_req, dmem_ready, imem_ready, cnt_clr;
    logic       pc_wen, dmem_valid, bus_err;
    logic [4:0] stage_wen, stage_clr;
    logic [3:0] stall_count;
    logic [1:0] dm_state;

    typedef struct {
        string       name;
        logic [18:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_redirect   (ex_redirect),
        .mem_req       (mem_req),
        .dmem_ready    (dmem_ready),
        .imem_ready    (imem_ready),
        .cnt_clr       (cnt_clr),
        .pc_wen        (pc_wen),
        .stage_wen     (stage_wen),
        .stage_clr     (stage_clr),
        .dmem_valid    (dmem_valid),
        .bus_err       (bus_err),
        .stall_count   (stall_count),
        .dm_state      (dm_state)
    );

    // Vector layout: {pc_wen, stage_wen, stage_clr, dmem_valid, bus_err, stall_count, dm_state}
    task automatic expect_out(input string name, input logic pc, input logic [4:0] wen,
                              input logic [4:0] clr, input logic dv, input logic be,
                              input logic [3:0] sc, input logic [1:0] st);
        exp_t e;
        e.name = name;
        e.v    = {pc, wen, clr, dv, be, sc, st};
        sb_q.push_back(e);
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_to_reg = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1; cnt_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every queued expectation against the DUT on the falling edge
    initial begin
        exp_t        e;
        logic [18:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {pc_wen, stage_wen, stage_clr, dmem_valid, bus_err, stall_count, dm_state};
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: actual pc/wen/clr/dv/be/cnt/st=%b_%b_%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b_%b_%b",
                             e.name, act[18], act[17:13], act[12:8], act[7], act[6], act[5:2], act[1:0],
                             e.v[18], e.v[17:13], e.v[12:8], e.v[7], e.v[6], e.v[5:2], e.v[1:0]);
                end
            end
        end
    end

    initial begin
        int s;
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        mem_req = 1'b1;
        expect_out("reset_hold", 0, 5'b00000, 5'b11111, 0, 0, 4'd0, 2'd0);
        tick();

        // Release: one flush cycle, then defaults
        reset_n = 1'b1;
        idle_inputs();
        expect_out("release_first", 0, 5'b00000, 5'b11111, 0, 0, 4'd0, 2'd0);
        tick();
        expect_out("release_default", 1, 5'b11111, 5'b00000, 0, 0, 4'd0, 2'd0);
        tick();

        // Load-use on rs1 (x5)
        ex_mem_to_reg = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        id_rs2 = 5'd3; id_uses_rs2 = 1'b1;
        expect_out("load_use_rs1", 0, 5'b11100, 5'b00100, 0, 0, 4'd0, 2'd0);
        tick();
        idle_inputs();
        expect_out("after_load_use", 1, 5'b11111, 5'b00000, 0, 0, 4'd1, 2'd0);
        tick();
        ex_mem_to_reg = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        expect_out("load_use_rs2", 0, 5'b11100, 5'b00100, 0, 0, 4'd1, 2'd0);
        tick();
        id_uses_rs2 = 1'b0;
        expect_out("no_use_flag", 1, 5'b11111, 5'b00000, 0, 0, 4'd2, 2'd0);
        tick();
        ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        expect_out("ex_rd_zero", 1, 5'b11111, 5'b00000, 0, 0, 4'd2, 2'd0);
        tick();
        ex_mem_to_reg = 1'b0; ex_rd = 5'd9; id_rs1 = 5'd9;
        expect_out("not_a_load", 1, 5'b11111, 5'b00000, 0, 0, 4'd2, 2'd0);
        tick();

        // Fetch stall, then redirect overriding fetch stall and load-use
        idle_inputs();
        imem_ready = 1'b0;
        expect_out("imem_stall", 0, 5'b11110, 5'b00010, 0, 0, 4'd2, 2'd0);
        tick();
        ex_redirect = 1'b1; ex_mem_to_reg = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1'b1;
        expect_out("redirect_wins", 1, 5'b11111, 5'b00111, 0, 0, 4'd3, 2'd0);
        tick();

        // Data-memory wait, ready low for three cycles
        idle_inputs();
        mem_req = 1'b1; dmem_ready = 1'b0;
        expect_out("dm_wait_c0", 0, 5'b10000, 5'b10000, 1, 0, 4'd3, 2'd0);
        tick();
        ex_redirect = 1'b1;
        expect_out("dm_wait_redirect", 0, 5'b10000, 5'b10000, 1, 0, 4'd4, 2'd1);
        tick();
        ex_redirect = 1'b0;
        expect_out("dm_wait_c2", 0, 5'b10000, 5'b10000, 1, 0, 4'd5, 2'd1);
        tick();
        dmem_ready = 1'b1;
        expect_out("dm_wait_done", 1, 5'b11111, 5'b00000, 1, 0, 4'd6, 2'd1);
        tick();
        expect_out("dm_idle_hit", 1, 5'b11111, 5'b00000, 1, 0, 4'd6, 2'd0);
        tick();

        // Timeout with TIMEOUT=4
        dmem_ready = 1'b0;
        expect_out("to_c0", 0, 5'b10000, 5'b10000, 1, 0, 4'd6, 2'd0);
        tick();
        expect_out("to_c1", 0, 5'b10000, 5'b10000, 1, 0, 4'd7, 2'd1);
        tick();
        expect_out("to_c2", 0, 5'b10000, 5'b10000, 1, 0, 4'd8, 2'd1);
        tick();
        expect_out("to_c3", 0, 5'b10000, 5'b10000, 1, 0, 4'd9, 2'd1);
        tick();
        expect_out("to_err", 1, 5'b11111, 5'b00000, 0, 1, 4'd10, 2'd2);
        tick();
        mem_req = 1'b0;
        expect_out("err_sticky", 1, 5'b11111, 5'b00000, 0, 1, 4'd10, 2'd0);
        tick();

        // Counter saturation and clear-over-increment
        idle_inputs();
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s = 10 + i;
            if (s > 15) s = 15;
            expect_out("saturate", 0, 5'b11110, 5'b00010, 0, 1, 4'(s), 2'd0);
            tick();
        end
        cnt_clr = 1'b1;
        expect_out("clr_during_stall", 0, 5'b11110, 5'b00010, 0, 1, 4'd15, 2'd0);
        tick();
        idle_inputs();
        expect_out("after_clr", 1, 5'b11111, 5'b00000, 0, 1, 4'd0, 2'd0);
        tick();

        // Reset asserted mid-wait abandons the access
        mem_req = 1'b1; dmem_ready = 1'b0;
        expect_out("pre_rst_c0", 0, 5'b10000, 5'b10000, 1, 1, 4'd0, 2'd0);
        tick();
        expect_out("pre_rst_wait", 0, 5'b10000, 5'b10000, 1, 1, 4'd1, 2'd1);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        expect_out("rst_in_wait", 0, 5'b00000, 5'b11111, 0, 0, 4'd0, 2'd0);
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        idle_inputs();
        expect_out("rerelease_first", 0, 5'b00000, 5'b11111, 0, 0, 4'd0, 2'd0);
        tick();
        expect_out("rerelease_default", 1, 5'b11111, 5'b00000, 0, 0, 4'd0, 2'd0);
        tick();

        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles a data-memory access may wait before abort.
REQ-002 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads that source.
REQ-007 SHALL have ports ex_rd  input  5, ex_mem_to_reg  input  1  destination of EX instruction, and whether EX holds a load.
REQ-008 SHALL have port ex_redirect  input  1  EX resolved a taken branch or jump.
REQ-009 SHALL have port mem_req  input  1  MEM instruction is a load or store.
REQ-010 SHALL have ports dmem_ready, imem_ready  input  1 each  data-memory ack, and IF2 fetch data valid.
REQ-011 SHALL have port cnt_clr  input  1  synchronous clear of stall_count.
REQ-012 SHALL have ports pc_wen  output  1, stage_wen  output  5, stage_clr  output  5: write enable and clear per pipeline register, bit index [0]=IF1/IF2, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB.
REQ-013 SHALL have ports dmem_valid  output  1, bus_err  output  1 (sticky), stall_count  output  CNT_W, dm_state  output  2.

Function
REQ-014 SHALL hold a run flag cleared by reset and set on the first clk edge after reset release; while run=0: pc_wen=0, stage_wen=0, stage_clr=5'b11111, dmem_valid=0.
REQ-015 SHALL implement data-memory FSM DM_IDLE(0), DM_WAIT(1), DM_ERR(2); dm_state reflects the current state.
REQ-016 DM_IDLE: mem_req & dmem_ready -> stay DM_IDLE, no stall; mem_req & ~dmem_ready -> DM_WAIT, wait counter loaded with 1.
REQ-017 DM_WAIT: dmem_ready -> DM_IDLE; else counter == TIMEOUT-1 -> DM_ERR; else counter increments.
REQ-018 DM_ERR: lasts exactly one cycle, sets bus_err, treats the access as complete, -> DM_IDLE.
REQ-019 dmem_valid SHALL equal mem_req & run & (state is DM_IDLE or DM_WAIT).
REQ-020 mem_stall = dmem_valid & ~dmem_ready; load_use = ex_mem_to_reg & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-021 Default (no event): pc_wen=1, stage_wen=5'b11111, stage_clr=0.
REQ-022 Priority 1, mem_stall: pc_wen=0, stage_wen[3:0]=0, stage_clr[4]=1 (bubble into WB); ex_redirect ignored that cycle.
REQ-023 Priority 2, ex_redirect: pc_wen=1, stage_clr[2:0]=3'b111, stage_wen[4:3]=1; overrides load_use and fetch stall.
REQ-024 Priority 3, load_use: pc_wen=0, stage_wen[1:0]=0, stage_clr[2]=1, stage_wen[4:3]=1.
REQ-025 Priority 4, ~imem_ready: pc_wen=0, stage_wen[0]=0, stage_clr[1]=1, stage_wen[4:2]=1.
REQ-026 stage_clr[i]=1 SHALL take precedence over stage_wen[i] at the register.
REQ-027 stall_count SHALL increment every run cycle with pc_wen=0, saturate at all-ones, and clear on cnt_clr (cnt_clr wins over increment).
REQ-028 bus_err SHALL clear only on reset.
REQ-029 All outputs except registered state SHALL be combinational from state and inputs, zero cycles of latency.

Reset
REQ-030 Reset SHALL force run=0, DM_IDLE, wait counter 0, bus_err=0, stall_count=0, immediately and asynchronously; reset mid-DM_WAIT abandons the access with no bus_err.

Structure
REQ-031 Stage index constants and enum dm_state_t SHALL live in package riscv_types.
REQ-032 Load-use comparison SHALL be a combinational sub-module hazard_detect.

Verification
REQ-033 Load x5 in EX, ID add reads x5 -> one cycle pc_wen=0, stage_clr[2]=1, stall_count=1; ex_rd=0 gives no stall.
REQ-034 mem_req=1, dmem_ready low 3 cycles -> DM_WAIT for 3 cycles, stage_wen[3:0]=0, stage_clr[4]=1; completes on ready.
REQ-035 TIMEOUT=4, dmem_ready stuck 0 -> DM_ERR on 4th wait cycle, bus_err=1 sticky, pipeline advances next cycle.
REQ-036 ex_redirect with imem_ready=0 and load_use=1 -> pc_wen=1, stage_clr=5'b00111; ex_redirect with mem_stall -> stage_clr=5'b10000.
REQ-037 Release reset -> first cycle stage_clr=5'b11111, second cycle defaults; reset asserted during DM_WAIT -> DM_IDLE, bus_err=0.
REQ-038 CNT_W=4, 20 stall cycles -> stall_count=15; cnt_clr concurrent with stall -> 0.
